dpram_port_bridge: RTL and testbench
====================================

// Module: dpram_port_bridge
// PURPOSE
//  Upstream master for one dpram port (A or B). Buffers client requests in a request FIFO and
//  issues them over the port's valid/ready handshake. Captures q one cycle after each accepted
//  transaction and returns it through a response FIFO with its own valid/ready handshake.
//  Credit logic guarantees every issued transaction has a response slot, so no q value is lost.
// PARAMETERS
//  ADDR_W     6  address width; matches dpram addr_a/addr_b
//  DATA_W     8  data width; matches dpram data/q
//  REQ_DEPTH  4  request FIFO entries; power of 2, >=2
//  RSP_DEPTH  4  response FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1       rising-edge clock, shared with dpram
//  rst        in   1       asynchronous reset, active-high
//  req_valid  in   1       client request valid
//  req_ready  out  1       request FIFO not full
//  req_we     in   1       1=write, 0=read
//  req_addr   in   ADDR_W  request address
//  req_data   in   DATA_W  write data; ignored for reads
//  mem_valid  out  1       to dpram valid_x
//  mem_ready  in   1       from dpram ready_x
//  mem_we     out  1       to dpram we_x
//  mem_addr   out  ADDR_W  to dpram addr_x
//  mem_data   out  DATA_W  to dpram data_x
//  mem_q      in   DATA_W  from dpram q_x
//  rsp_valid  out  1       response FIFO not empty
//  rsp_ready  in   1       client accepts response
//  rsp_we     out  1       response belongs to a write
//  rsp_data   out  DATA_W  read data, or echoed write data for writes
//  busy       out  1       req FIFO non-empty, or capture pending, or rsp FIFO non-empty
// BEHAVIOUR
//  Reset: FIFOs empty, pointers/counters 0, pend=0. req_ready=1; mem_valid, rsp_valid, busy=0.
//   mem_*/rsp_* data outputs = 0 while their FIFO is empty.
//  Request FIFO:
//   - Push on req_valid&req_ready. req_ready=!req_full, taken from registered count only.
//   - A pop in the same cycle does not raise req_ready. No fall-through: earliest issue is
//     the cycle after the push.
//  Issue:
//   - mem_valid = !req_empty && (rsp_count + pend) < RSP_DEPTH. Combinational from registers.
//   - mem_we/addr/data = request FIFO head.
//   - Head pops on mem_valid&mem_ready. Once raised, mem_valid holds with stable fields until
//     the handshake completes.
//  Capture:
//   - pend <= mem_valid&mem_ready, with the op's we saved alongside.
//   - When pend=1, push {we, mem_q} into the response FIFO on that edge. dpram q is valid the
//     cycle after the handshake.
//   - Capture must never find the response FIFO full; the credit rule guarantees this.
//   - Back-to-back issue every cycle is allowed.
//  Response FIFO:
//   - rsp_valid = !rsp_empty. Pop on rsp_valid&rsp_ready. rsp_we/rsp_data = head, stable
//     while stalled.
//   - Simultaneous push and pop: count unchanged, both take effect.
//  Latency, no stalls: req accepted at edge E -> mem handshake at E+1 -> capture at E+2 ->
//   rsp_valid high from E+2 onward.
//  Ordering: responses come out strictly in request order. Pointers wrap modulo depth; full
//   and empty are derived from counts.
//  Reset mid-operation: all queued requests, the pending capture and all responses are
//   discarded immediately. No mem_valid is asserted until a new request arrives.
//  Hazards: a read issued after a write to the same address on this port returns the new data
//   (dpram ordering). Cross-port collisions are the client's responsibility.
// TESTING
//  T1 Write 0xA5 @0x10, then read @0x10 -> two responses in order: {we=1,0xA5}, {we=0,0xA5}.
//  T2 rsp_ready=0, 10 reads issued -> exactly RSP_DEPTH mem handshakes; mem_valid=0 after
//     that; req_ready=0 once the req FIFO fills.
//  T3 Release rsp_ready after T2 -> all 10 responses delivered, in order, none lost or
//     duplicated.
//  T4 Streaming reads @0..63 with rsp_ready=1 -> one handshake per cycle; rsp_data[i]
//     matches preloaded ram[i]; address wraps 63->0 cleanly.
//  T5 Assert rst with 3 requests queued and pend=1 -> next cycle mem_valid=0, rsp_valid=0,
//     req_ready=1, busy=0.
//  T6 Random traffic against a reference model with random rsp_ready and req_valid
//     -> zero mismatches; mem fields never change while mem_valid=1 and handshake is pending.

Source files
------------

// File: rtl/dpram_port_bridge.sv
// Upstream master for one dpram port: request FIFO, valid/ready issue, one-cycle q capture,
// and a credit-protected response FIFO so no read data is ever dropped.
module dpram_port_bridge #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  localparam int unsigned REQ_AW = $clog2(REQ_DEPTH);
  localparam int unsigned RSP_AW = $clog2(RSP_DEPTH);
  localparam int unsigned REQ_CW = REQ_AW + 1;
  localparam int unsigned RSP_CW = RSP_AW + 1;
  localparam int unsigned CRD_W  = RSP_AW + 2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] data;
  } rsp_t;

  req_t              req_mem [REQ_DEPTH];
  logic [REQ_AW-1:0] req_wr_ptr, req_rd_ptr;
  logic [REQ_CW-1:0] req_count;
  logic              req_empty, req_push, req_pop;

  rsp_t              rsp_mem [RSP_DEPTH];
  logic [RSP_AW-1:0] rsp_wr_ptr, rsp_rd_ptr;
  logic [RSP_CW-1:0] rsp_count;
  logic              rsp_empty, rsp_push, rsp_pop;
  rsp_t              rsp_in;

  logic              pend, pend_we;
  logic [DATA_W-1:0] pend_data;
  logic [CRD_W-1:0]  rsp_used;
  req_t              req_head;
  rsp_t              rsp_head;

  // Status and handshakes, all derived from registered state
  always_comb begin
    req_empty = (req_count == REQ_CW'(0));
    req_ready = (req_count != REQ_CW'(REQ_DEPTH));
    rsp_empty = (rsp_count == RSP_CW'(0));
    rsp_used  = CRD_W'(rsp_count) + CRD_W'(pend);
    mem_valid = !req_empty && (rsp_used < CRD_W'(RSP_DEPTH));
    req_push  = req_valid && req_ready;
    req_pop   = mem_valid && mem_ready;
    rsp_valid = !rsp_empty;
    rsp_pop   = rsp_valid && rsp_ready;
    rsp_push  = pend;
    busy      = !req_empty || pend || !rsp_empty;
  end

  // Head fields forced to zero while the corresponding FIFO is empty
  always_comb begin
    req_head = req_empty ? '0 : req_mem[req_rd_ptr];
    mem_we   = req_head.we;
    mem_addr = req_head.addr;
    mem_data = req_head.data;
    rsp_head = rsp_empty ? '0 : rsp_mem[rsp_rd_ptr];
    rsp_we   = rsp_head.we;
    rsp_data = rsp_head.data;
  end

  // Writes echo their own data; reads take q, valid the cycle after the handshake
  always_comb begin
    rsp_in.we   = pend_we;
    rsp_in.data = pend_we ? pend_data : mem_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_wr_ptr <= '0;
      req_rd_ptr <= '0;
      req_count  <= '0;
    end else begin
      if (req_push) req_wr_ptr <= req_wr_ptr + REQ_AW'(1);
      if (req_pop)  req_rd_ptr <= req_rd_ptr + REQ_AW'(1);
      case ({req_push, req_pop})
        2'b10:   req_count <= req_count + REQ_CW'(1);
        2'b01:   req_count <= req_count - REQ_CW'(1);
        default: req_count <= req_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (req_push) req_mem[req_wr_ptr] <= '{we: req_we, addr: req_addr, data: req_data};
    if (rsp_push) rsp_mem[rsp_wr_ptr] <= rsp_in;
  end

  // Capture stage: one outstanding op whose q arrives on the next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= 1'b0;
      pend_we   <= 1'b0;
      pend_data <= '0;
    end else begin
      pend <= req_pop;
      if (req_pop) begin
        pend_we   <= mem_we;
        pend_data <= mem_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_count  <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + RSP_AW'(1);
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + RSP_AW'(1);
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count <= rsp_count + RSP_CW'(1);
        2'b01:   rsp_count <= rsp_count - RSP_CW'(1);
        default: rsp_count <= rsp_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_port_bridge.sv
// Scoreboard bench for dpram_port_bridge with a behavioural single-port dpram model.
module tb_dpram_port_bridge;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              mem_valid, mem_ready, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data, mem_q;
  logic              rsp_valid, rsp_ready, rsp_we;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  logic rand_rdy = 1'b0, rnd_mr = 1'b1, rnd_rr = 1'b1, fix_mr, fix_rr;
  assign mem_ready = rand_rdy ? rnd_mr : fix_mr;
  assign rsp_ready = rand_rdy ? rnd_rr : fix_rr;

  dpram_port_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REQ_DEPTH(4), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_q(mem_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ram [64];
  logic [7:0]  ref_mem [64];
  int          checks = 0, errors = 0, stalls = 0;
  int          cyc = 0, hs_cnt = 0, mark_idx = -1, first_hs_cyc = 0, last_hs_cyc = 0;

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // dpram port model: q is valid the cycle after the handshake, write-first
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_val(i);
      mem_q <= '0;
    end else if (mem_valid && mem_ready) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_data;
        mem_q         <= mem_data;
      end else begin
        mem_q <= ram[mem_addr];
      end
      hs_cnt      <= hs_cnt + 1;
      last_hs_cyc <= cyc;
      if (hs_cnt == mark_idx) first_hs_cyc <= cyc;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    rnd_mr = 1'($urandom_range(0, 1));
    rnd_rr = 1'($urandom_range(0, 1));
  end

  // Response monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got we=%0d data=%h, expected no response", rsp_we, rsp_data);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_we, rsp_data} !== e) begin
          errors++;
          $display("FAIL rsp_data: got we=%0d data=%h, expected we=%0d data=%h",
                   rsp_we, rsp_data, e.we, e.data);
        end
      end
    end
  end

  // Issue fields must hold while a handshake is pending
  initial begin
    logic pv = 1'b0, pr = 1'b0, pwe = 1'b0;
    logic [ADDR_W-1:0] pa = '0;
    logic [DATA_W-1:0] pd = '0;
    forever begin
      @(negedge clk);
      if (!rst && pv && !pr) begin
        checks++;
        if (!mem_valid || mem_we !== pwe || mem_addr !== pa || mem_data !== pd) begin
          errors++;
          $display("FAIL mem_stable: got v=%0d we=%0d a=%h d=%h, expected v=1 we=%0d a=%h d=%h",
                   mem_valid, mem_we, mem_addr, mem_data, pwe, pa, pd);
        end
      end
      pv = rst ? 1'b0 : mem_valid;
      pr = mem_ready; pwe = mem_we; pa = mem_addr; pd = mem_data;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic send(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic acc;
    int   n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_data = d;
    forever begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      if (acc) break;
      stalls++;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL req_accept_timeout: got req_ready=0 for %0d cycles, expected acceptance", n);
        break;
      end
    end
    if (acc) begin
      exp_q.push_back(we ? exp_t'{1'b1, d} : exp_t'{1'b0, ref_mem[a]});
      if (we) ref_mem[a] = d;
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, exp_q.size() + int'(busy), 0);
  endtask

  initial begin
    int hs0, st0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
    fix_mr = 1'b1; fix_rr = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", int'(req_ready), 1);
    chk("reset_mem_valid", int'(mem_valid), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_mem_fields", int'({mem_we, mem_addr, mem_data}), 0);
    chk("reset_rsp_fields", int'({rsp_we, rsp_data}), 0);
    @(posedge clk); #1 rst = 1'b0;

    // T1: write then read same address
    send(1'b1, 6'h10, 8'hA5);
    send(1'b0, 6'h10, 8'h00);
    drain("t1_drained");

    // T2: responses blocked, only RSP_DEPTH ops may issue
    fix_rr = 1'b0;
    hs0 = hs_cnt;
    for (int i = 0; i < 8; i++) send(1'b0, 6'(20 + i), 8'h00);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t2_handshakes", hs_cnt - hs0, 4);
    chk("t2_mem_valid", int'(mem_valid), 0);
    chk("t2_req_ready", int'(req_ready), 0);
    chk("t2_rsp_valid", int'(rsp_valid), 1);

    // T3: release responses and push the remaining two
    @(posedge clk); #1 fix_rr = 1'b1;
    send(1'b0, 6'd28, 8'h00);
    send(1'b0, 6'd29, 8'h00);
    drain("t3_drained");
    chk("t3_handshakes", hs_cnt - hs0, 10);

    // T4: streaming reads over the full address space plus wrap
    hs0 = hs_cnt; st0 = stalls; mark_idx = hs_cnt;
    for (int i = 0; i < 65; i++) send(1'b0, 6'(i), 8'h00);
    drain("t4_drained");
    chk("t4_handshakes", hs_cnt - hs0, 65);
    chk("t4_span", last_hs_cyc - first_hs_cyc, 64);
    chk("t4_stalls", stalls - st0, 0);

    // T5: reset with three queued requests and one capture pending
    fix_mr = 1'b0;
    for (int i = 1; i <= 4; i++) send(1'b0, 6'(i), 8'h00);
    fix_mr = 1'b1;
    @(posedge clk); #1 fix_mr = 1'b0;
    chk("t5_busy_before", int'(busy), 1);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("t5_mem_valid", int'(mem_valid), 0);
    chk("t5_rsp_valid", int'(rsp_valid), 0);
    chk("t5_req_ready", int'(req_ready), 1);
    chk("t5_busy", int'(busy), 0);
    @(posedge clk); #1 rst = 1'b0; fix_mr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_idle_after", int'(mem_valid | rsp_valid | busy), 0);
    @(posedge clk); #1;

    // T6: random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 120; i++) begin
      send(1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0; fix_mr = 1'b1; fix_rr = 1'b1;
    drain("t6_drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
